// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_pkg
// Description : Shared card word layout, widths, list terminator and reader
//               FSM state encoding for the card RAM blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

  localparam int CARD_ADDR_W    = 10;
  localparam int CARD_WORD_W    = 32;
  localparam int COUNT_W        = 7;

  // Field positions inside a card word
  localparam int CARD_OCC_BIT   = 31;
  localparam int CARD_SUIT_LSB  = 20;
  localparam int CARD_SUIT_W    = 2;
  localparam int CARD_VALUE_LSB = 16;
  localparam int CARD_VALUE_W   = 4;
  localparam int CARD_NEXT_LSB  = 0;

  // Address 0 is reserved: a next pointer of 0 ends the list
  localparam logic [CARD_ADDR_W-1:0] NULL_ADDR = 10'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } reader_state_e;

  // Saturating increment: the card counter sticks at its maximum
  function automatic logic [COUNT_W-1:0] count_sat_inc(input logic [COUNT_W-1:0] c);
    count_sat_inc = (c == {COUNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_word_unpack.sv
`default_nettype none
// ============================================================================
// Module      : card_word_unpack
// Description : Combinational split of a card RAM word into occupied flag,
//               suit, value and next-card pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module card_word_unpack
  import card_pkg::*;
(
  input  logic [CARD_WORD_W-1:0]  word,
  output logic                    occupied,
  output logic [CARD_SUIT_W-1:0]  suit,
  output logic [CARD_VALUE_W-1:0] value,
  output logic [CARD_ADDR_W-1:0]  next_addr
);

  assign occupied  = word[CARD_OCC_BIT];
  assign suit      = word[CARD_SUIT_LSB  +: CARD_SUIT_W];
  assign value     = word[CARD_VALUE_LSB +: CARD_VALUE_W];
  assign next_addr = word[CARD_NEXT_LSB  +: CARD_ADDR_W];

  // Remaining bits carry no meaning for card handling
  logic unused_bits;
  assign unused_bits = ^{word[CARD_OCC_BIT-1:CARD_SUIT_LSB+CARD_SUIT_W],
                         word[CARD_VALUE_LSB-1:CARD_NEXT_LSB+CARD_ADDR_W]};

endmodule
`default_nettype wire

// File: rtl/card_list_reader.sv
`default_nettype none
// ============================================================================
// Module      : card_list_reader
// Description : Walks a linked list of cards in the card RAM from a head
//               address and streams each card out on a valid/ready port.
//               Optional: CARD_LIST_READER_LOOP_GUARD_EN aborts a walk with
//               error once MAX_CARDS cards are accepted without reaching the
//               end of the list.
// Revision    : 1.0 - initial release
// ============================================================================
module card_list_reader
  import card_pkg::*;
#(
  parameter int                      RD_LATENCY = 1,
  parameter int                      MAX_CARDS  = 52,
  parameter logic [CARD_ADDR_W-1:0]  NULL_ADDR  = card_pkg::NULL_ADDR
)(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CARD_ADDR_W-1:0]  head_addr,
  output logic                    busy,
  output logic [CARD_ADDR_W-1:0]  ram_addr,
  input  logic [CARD_WORD_W-1:0]  ram_q,
  output logic                    card_valid,
  input  logic                    card_ready,
  output logic [CARD_VALUE_W-1:0] card_value,
  output logic [CARD_SUIT_W-1:0]  card_suit,
  output logic [CARD_ADDR_W-1:0]  card_addr,
  output logic                    card_last,
  output logic                    done,
  output logic                    error,
  output logic [COUNT_W-1:0]      count
);

  // ram_addr is the RAM's address register; data for it is usable
  // RD_LATENCY edges later, so WAIT spends RD_LATENCY edges (load = L-1).
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

`ifdef CARD_LIST_READER_LOOP_GUARD_EN
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_CARDS);
`else
  logic unused_max_cards;
  assign unused_max_cards = |COUNT_W'(MAX_CARDS);
`endif

  reader_state_e             state_q, state_d;
  logic [1:0]                wait_cnt_q, wait_cnt_d;
  logic                      busy_q, busy_d;
  logic [CARD_ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic                      card_valid_q, card_valid_d;
  logic [CARD_VALUE_W-1:0]   card_value_q, card_value_d;
  logic [CARD_SUIT_W-1:0]    card_suit_q, card_suit_d;
  logic [CARD_ADDR_W-1:0]    card_addr_q, card_addr_d;
  logic                      card_last_q, card_last_d;
  logic [CARD_ADDR_W-1:0]    next_addr_q, next_addr_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [COUNT_W-1:0]        count_q, count_d;

  logic                      word_occupied;
  logic [CARD_SUIT_W-1:0]    word_suit;
  logic [CARD_VALUE_W-1:0]   word_value;
  logic [CARD_ADDR_W-1:0]    word_next;
  logic [COUNT_W-1:0]        count_inc;

  card_word_unpack u_unpack (
    .word      (ram_q),
    .occupied  (word_occupied),
    .suit      (word_suit),
    .value     (word_value),
    .next_addr (word_next)
  );

  assign count_inc = count_sat_inc(count_q);

  // Next-state and registered-output computation for the list walk
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    busy_d       = busy_q;
    ram_addr_d   = ram_addr_q;
    card_valid_d = card_valid_q;
    card_value_d = card_value_q;
    card_suit_d  = card_suit_q;
    card_addr_d  = card_addr_q;
    card_last_d  = card_last_q;
    next_addr_d  = next_addr_q;
    done_d       = 1'b0;
    error_d      = error_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (head_addr == NULL_ADDR) begin
            state_d = ST_DONE;
          end else begin
            ram_addr_d = head_addr;
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q != 2'd0) begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end else if (!word_occupied) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          card_value_d = word_value;
          card_suit_d  = word_suit;
          card_addr_d  = ram_addr_q;
          card_last_d  = (word_next == NULL_ADDR);
          next_addr_d  = word_next;
          card_valid_d = 1'b1;
          state_d      = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (card_ready) begin
          card_valid_d = 1'b0;
          count_d      = count_inc;
          if (card_last_q) begin
            state_d = ST_DONE;
`ifdef CARD_LIST_READER_LOOP_GUARD_EN
          end else if (count_inc == MAX_COUNT) begin
            // Too many cards without a terminator: treat list as corrupt
            error_d = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            ram_addr_d = next_addr_q;
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 2'd0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      card_valid_q <= 1'b0;
      card_value_q <= '0;
      card_suit_q  <= '0;
      card_addr_q  <= '0;
      card_last_q  <= 1'b0;
      next_addr_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      busy_q       <= busy_d;
      ram_addr_q   <= ram_addr_d;
      card_valid_q <= card_valid_d;
      card_value_q <= card_value_d;
      card_suit_q  <= card_suit_d;
      card_addr_q  <= card_addr_d;
      card_last_q  <= card_last_d;
      next_addr_q  <= next_addr_d;
      done_q       <= done_d;
      error_q      <= error_d;
      count_q      <= count_d;
    end
  end

  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign card_valid = card_valid_q;
  assign card_value = card_value_q;
  assign card_suit  = card_suit_q;
  assign card_addr  = card_addr_q;
  assign card_last  = card_last_q;
  assign done       = done_q;
  assign error      = error_q;
  assign count      = count_q;

endmodule
`default_nettype wire
